// File: rtl/scan_receiver_if.sv
// Bus bundle between the dual ping-pong scanners, the receiver and the CPU read port.
// The receiver uses the slave modport; the scanner/CPU side uses master.
interface scan_receiver_if #(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              ready1;
   logic              ready2;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic [7:0]        data1;
   logic [7:0]        data2;
   logic              transfer1;
   logic              transfer2;
   logic              rd_en;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              burst_done;
   logic              last_src;
   logic              overflow;

   modport master (
      output ready1, ready2, addr1, addr2, data1, data2, rd_en,
      input  transfer1, transfer2, rd_data, rd_valid, count, empty, full,
             burst_done, last_src, overflow
   );

   modport slave (
      input  ready1, ready2, addr1, addr2, data1, data2, rd_en,
      output transfer1, transfer2, rd_data, rd_valid, count, empty, full,
             burst_done, last_src, overflow
   );
endinterface

// File: rtl/scan_receiver.sv
// Receiving end of the dual scanner transfer path: round-robin grant of whole bursts,
// capture into a circular byte FIFO, and a registered CPU read port.
module scan_receiver #(
   parameter int BURST  = 10,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 32
) (
   input  logic            clk,
   input  logic            rst,
   scan_receiver_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, XFER1, XFER2} state_t;

   state_t           state_q, state_d;
   logic             transfer1_q, transfer1_d;
   logic             transfer2_q, transfer2_d;
   logic             burst_done_q, burst_done_d;
   logic             last_src_q, last_src_d;
   logic             overflow_q, overflow_d;
   logic             rd_valid_q, rd_valid_d;
   logic [7:0]       rd_data_q;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       mem [DEPTH];

   logic       empty, full, space_ok;
   logic       grant1, grant2;
   logic       wr_req, wr_accept, rd_accept;
   logic [7:0] wr_byte;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   // A whole burst must fit before it is granted, so the FIFO never overruns mid-burst.
   assign space_ok = (count_q <= CNT_W'(DEPTH - BURST));
   // On a tie the scanner that did not win last time is served.
   assign grant1   = bus.ready1 & (~bus.ready2 | last_src_q);
   assign grant2   = bus.ready2 & (~bus.ready1 | ~last_src_q);

   assign wr_req    = transfer1_q | transfer2_q;
   assign wr_byte   = transfer1_q ? bus.data1 : bus.data2;
   assign rd_accept = bus.rd_en & ~empty;
   assign wr_accept = wr_req & (~full | rd_accept);

   always_comb begin
      state_d      = state_q;
      transfer1_d  = transfer1_q;
      transfer2_d  = transfer2_q;
      last_src_d   = last_src_q;
      burst_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (space_ok && grant1) begin
               state_d     = XFER1;
               transfer1_d = 1'b1;
               last_src_d  = 1'b0;
            end else if (space_ok && grant2) begin
               state_d     = XFER2;
               transfer2_d = 1'b1;
               last_src_d  = 1'b1;
            end
         end
         XFER1: begin
            if (bus.addr1 == ADDR_W'(0)) begin
               state_d      = IDLE;
               transfer1_d  = 1'b0;
               burst_done_d = 1'b1;
            end
         end
         XFER2: begin
            if (bus.addr2 == ADDR_W'(0)) begin
               state_d      = IDLE;
               transfer2_d  = 1'b0;
               burst_done_d = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            transfer1_d = 1'b0;
            transfer2_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d   = wr_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = rd_accept ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q + CNT_W'(wr_accept) - CNT_W'(rd_accept);
      rd_valid_d = rd_accept;
      overflow_d = overflow_q | (wr_req & full & ~rd_accept);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         transfer1_q  <= 1'b0;
         transfer2_q  <= 1'b0;
         burst_done_q <= 1'b0;
         last_src_q   <= 1'b1;
         overflow_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         transfer1_q  <= transfer1_d;
         transfer2_q  <= transfer2_d;
         burst_done_q <= burst_done_d;
         last_src_q   <= last_src_d;
         overflow_q   <= overflow_d;
         rd_valid_q   <= rd_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Storage array kept free of reset so it maps onto block RAM with a registered read.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= wr_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data_q <= '0;
      end else if (rd_accept) begin
         rd_data_q <= mem[rd_ptr_q];
      end
   end

   assign bus.transfer1  = transfer1_q;
   assign bus.transfer2  = transfer2_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.count      = count_q;
   assign bus.empty      = empty;
   assign bus.full       = full;
   assign bus.burst_done = burst_done_q;
   assign bus.last_src   = last_src_q;
   assign bus.overflow   = overflow_q;
endmodule
